// File: rtl/sha2_pkg.sv
// -----------------------------------------------------------------------------
// sha2_pkg
// Constants shared by the SHA-2 packet datapaths. The input (IPU) side and the
// output (OPU) side use the same packet geometry.
//   PKT_W  packet width in bits
//   N_PKT  packets per block
//   IDX_W  packet index width, clog2(N_PKT)
//   BLK_W  block width, PKT_W * N_PKT
// -----------------------------------------------------------------------------
package sha2_pkg;

    localparam int PKT_W = 64;
    localparam int N_PKT = 8;
    localparam int IDX_W = 3;
    localparam int BLK_W = PKT_W * N_PKT;

    // Serializer states.
    typedef enum logic {
        OPU_IDLE = 1'b0,
        OPU_SEND = 1'b1
    } opu_state_e;

endpackage : sha2_pkg

// File: rtl/sha2_opu_dpath.sv
// -----------------------------------------------------------------------------
// sha2_opu_dpath
// Block-to-packet serializer. It takes one 512-bit block in a single load
// handshake and emits it as N_PKT packets of PKT_W bits each. The most
// significant word goes first, and each packet carries its index for the block
// assembler on the receiving side.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   clr       in   synchronous clear, active-high (drops any block in flight)
//   blk       in   block to serialize; word 0 = blk[BLK_W-1 -: PKT_W]
//   ld        in   load request, accepted when ld & ld_rdy
//   ld_rdy    out  serializer can accept a block
//   pkt       out  current packet
//   pkt_vld   out  pkt / idx / pkt_last valid
//   pkt_rdy   in   sink accepts packet; transfer = pkt_vld & pkt_rdy
//   idx       out  index of current packet
//   pkt_last  out  current packet is the final word of the block
//   done      out  one-cycle pulse after the final packet transfers
// -----------------------------------------------------------------------------
module sha2_opu_dpath
    import sha2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [BLK_W-1:0] blk,
    input  logic             ld,
    output logic             ld_rdy,
    output logic [PKT_W-1:0] pkt,
    output logic             pkt_vld,
    input  logic             pkt_rdy,
    output logic [IDX_W-1:0] idx,
    output logic             pkt_last,
    output logic             done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PKT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    opu_state_e       state_r;
    opu_state_e       state_nxt_s;
    logic [BLK_W-1:0] sreg_r;
    logic [BLK_W-1:0] sreg_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    // ld_rdy stays low during reset and rises on the first clock after release.
    logic             rdy_en_r;
    logic             last_s;

    assign last_s = (state_r == OPU_SEND) && (idx_r == IDX_LAST);

    // Next-state decode: clear first, then load in IDLE or shift in SEND.
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        idx_nxt_s   = idx_r;
        done_nxt_s  = 1'b0;
        if (clr) begin
            // Also suppresses done when clr lands on the final transfer.
            state_nxt_s = OPU_IDLE;
            sreg_nxt_s  = {BLK_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                OPU_IDLE: begin
                    if (ld && rdy_en_r) begin
                        state_nxt_s = OPU_SEND;
                        sreg_nxt_s  = blk;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        state_nxt_s = OPU_IDLE;
                    end
                end
                OPU_SEND: begin
                    if (pkt_rdy) begin
                        // Zero fill, so pkt reads 0 once the block has drained.
                        sreg_nxt_s = {sreg_r[BLK_W-PKT_W-1:0], {PKT_W{1'b0}}};
                        if (last_s) begin
                            state_nxt_s = OPU_IDLE;
                            idx_nxt_s   = {IDX_W{1'b0}};
                            done_nxt_s  = 1'b1;
                        end else begin
                            idx_nxt_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        state_nxt_s = OPU_SEND;
                    end
                end
                default: begin
                    state_nxt_s = OPU_IDLE;
                    sreg_nxt_s  = {BLK_W{1'b0}};
                    idx_nxt_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // State, shift register, index and done registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= OPU_IDLE;
            sreg_r   <= {BLK_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            done_r   <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sreg_r   <= sreg_nxt_s;
            idx_r    <= idx_nxt_s;
            done_r   <= done_nxt_s;
            rdy_en_r <= 1'b1;
        end
    end

    // Outputs come straight from registered state, so none depend on ld.
    assign ld_rdy   = rdy_en_r && (state_r == OPU_IDLE);
    assign pkt_vld  = (state_r == OPU_SEND);
    assign pkt      = sreg_r[BLK_W-1 -: PKT_W];
    assign idx      = idx_r;
    assign pkt_last = last_s;
    assign done     = done_r;

endmodule : sha2_opu_dpath

// File: tb/tb_sha2_opu_dpath.sv
// -----------------------------------------------------------------------------
// tb_sha2_opu_dpath
// Directed bench for the block-to-packet serializer. Inputs change 1 ns after
// the rising edge, and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_sha2_opu_dpath;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [511:0] blk;
    logic         ld;
    logic         ld_rdy;
    logic [63:0]  pkt;
    logic         pkt_vld;
    logic         pkt_rdy;
    logic [2:0]   idx;
    logic         pkt_last;
    logic         done;

    int checks;
    int errors;

    logic [63:0]  wa [8];
    logic [63:0]  wb [8];
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    sha2_opu_dpath dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .blk      (blk),
        .ld       (ld),
        .ld_rdy   (ld_rdy),
        .pkt      (pkt),
        .pkt_vld  (pkt_vld),
        .pkt_rdy  (pkt_rdy),
        .idx      (idx),
        .pkt_last (pkt_last),
        .done     (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a block for one edge. On return we are in the first post-load cycle.
    task automatic do_load(input logic [511:0] b);
        blk = b;
        ld  = 1'b1;
        step();
        ld  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({ld_rdy, pkt_vld, idx, pkt_last, done, pkt} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b idx=%0d last=%b done=%b pkt=%h, want all 0",
                     ld_rdy, pkt_vld, idx, pkt_last, done, pkt);
        end
        #21 rst = 1'b0;  // t=23, released mid-cycle
        #1;
        checks++;
        if (ld_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_before_clk: got %b want 0", ld_rdy);
        end
        step();
        checks++;
        if (ld_rdy !== 1'b1 || pkt_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_after_clk: got rdy=%b vld=%b want rdy=1 vld=0", ld_rdy, pkt_vld);
        end
    endtask

    task automatic test_stream();
        pkt_rdy = 1'b1;
        do_load(blk_a);
        for (int w = 0; w < 8; w++) begin
            checks++;
            if ({pkt_vld, idx, pkt_last, done, ld_rdy, pkt} !== {1'b1, 3'(w), (w == 7), 1'b0, 1'b0, wa[w]}) begin
                errors++;
                $display("FAIL stream_w%0d: got vld=%b idx=%0d last=%b done=%b rdy=%b pkt=%h want vld=1 idx=%0d last=%b done=0 rdy=0 pkt=%h",
                         w, pkt_vld, idx, pkt_last, done, ld_rdy, pkt, w, (w == 7), wa[w]);
            end
            step();
        end
        checks++;
        if ({done, ld_rdy, pkt_vld, idx, pkt} !== {1'b1, 1'b1, 1'b0, 3'd0, 64'd0}) begin
            errors++;
            $display("FAIL stream_done: got done=%b rdy=%b vld=%b idx=%0d pkt=%h want done=1 rdy=1 vld=0 idx=0 pkt=0",
                     done, ld_rdy, pkt_vld, idx, pkt);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        pkt_rdy = 1'b0;  // no effect while idle
        do_load(blk_a);
        // Word shown in post-load cycle c is (c+1)/2 when rdy alternates 1,0,1,0,...
        for (int c = 0; c < 15; c++) begin
            pkt_rdy = (c % 2 == 0);
            checks++;
            if ({pkt_vld, idx, done, pkt} !== {1'b1, 3'((c + 1) / 2), 1'b0, wa[(c + 1) / 2]}) begin
                errors++;
                $display("FAIL bp_c%0d: got vld=%b idx=%0d done=%b pkt=%h want vld=1 idx=%0d done=0 pkt=%h",
                         c, pkt_vld, idx, done, pkt, (c + 1) / 2, wa[(c + 1) / 2]);
            end
            step();
        end
        checks++;
        if ({done, pkt_vld} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done: got done=%b vld=%b want done=1 vld=0", done, pkt_vld);
        end
        pkt_rdy = 1'b1;
        step();
    endtask

    task automatic test_ld_ignored();
        pkt_rdy = 1'b1;
        do_load(blk_a);
        for (int w = 0; w < 8; w++) begin
            if (w == 2) begin
                blk = blk_b;
                ld  = 1'b1;
            end else if (w == 3) begin
                ld  = 1'b0;
            end else begin
                blk = blk;
            end
            checks++;
            if ({pkt_vld, idx, ld_rdy, pkt} !== {1'b1, 3'(w), 1'b0, wa[w]}) begin
                errors++;
                $display("FAIL ldign_w%0d: got vld=%b idx=%0d rdy=%b pkt=%h want vld=1 idx=%0d rdy=0 pkt=%h",
                         w, pkt_vld, idx, ld_rdy, pkt, w, wa[w]);
            end
            step();
        end
        checks++;
        if ({done, pkt_vld} !== 2'b10) begin
            errors++;
            $display("FAIL ldign_done: got done=%b vld=%b want done=1 vld=0", done, pkt_vld);
        end
        step();
    endtask

    task automatic test_clr();
        pkt_rdy = 1'b1;
        do_load(blk_a);
        step();
        step();
        step();
        checks++;
        if (idx !== 3'd3 || pkt !== wa[3]) begin
            errors++;
            $display("FAIL clr_pre: got idx=%0d pkt=%h want idx=3 pkt=%h", idx, pkt, wa[3]);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if ({pkt_vld, idx, done, ld_rdy, pkt} !== {1'b0, 3'd0, 1'b0, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL clr_mid: got vld=%b idx=%0d done=%b rdy=%b pkt=%h want vld=0 idx=0 done=0 rdy=1 pkt=0",
                     pkt_vld, idx, done, ld_rdy, pkt);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clr_nodone: got done=%b want 0", done);
        end
        // Restart, then clear exactly on the final transfer.
        do_load(blk_b);
        checks++;
        if ({pkt_vld, idx, pkt} !== {1'b1, 3'd0, wb[0]}) begin
            errors++;
            $display("FAIL clr_restart: got vld=%b idx=%0d pkt=%h want vld=1 idx=0 pkt=%h", pkt_vld, idx, pkt, wb[0]);
        end
        for (int w = 0; w < 7; w++) step();
        checks++;
        if ({idx, pkt_last, pkt} !== {3'd7, 1'b1, wb[7]}) begin
            errors++;
            $display("FAIL clr_last_pre: got idx=%0d last=%b pkt=%h want idx=7 last=1 pkt=%h", idx, pkt_last, pkt, wb[7]);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if ({done, pkt_vld, idx} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clr_last: got done=%b vld=%b idx=%0d want done=0 vld=0 idx=0", done, pkt_vld, idx);
        end
    endtask

    task automatic test_rst_mid();
        pkt_rdy = 1'b1;
        do_load(blk_a);
        for (int w = 0; w < 5; w++) step();
        checks++;
        if (idx !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_pre: got idx=%0d want 5", idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pkt_vld, idx, done, ld_rdy, pkt} !== 70'd0) begin
            errors++;
            $display("FAIL rstmid_async: got vld=%b idx=%0d done=%b rdy=%b pkt=%h want all 0",
                     pkt_vld, idx, done, ld_rdy, pkt);
        end
        #2 rst = 1'b0;
        step();
        checks++;
        if ({ld_rdy, done, pkt_vld} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_after: got rdy=%b done=%b vld=%b want rdy=1 done=0 vld=0", ld_rdy, done, pkt_vld);
        end
        do_load(blk_b);
        for (int w = 0; w < 8; w++) begin
            checks++;
            if ({pkt_vld, idx, pkt_last, pkt} !== {1'b1, 3'(w), (w == 7), wb[w]}) begin
                errors++;
                $display("FAIL rstmid_w%0d: got vld=%b idx=%0d last=%b pkt=%h want vld=1 idx=%0d last=%b pkt=%h",
                         w, pkt_vld, idx, pkt_last, pkt, w, (w == 7), wb[w]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: got done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        pkt_rdy = 1'b1;
        do_load(blk_a);
        for (int w = 0; w < 8; w++) step();
        // Bubble cycle: done and ld_rdy together, load the next block here.
        checks++;
        if ({done, ld_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_bubble: got done=%b rdy=%b want done=1 rdy=1", done, ld_rdy);
        end
        do_load(blk_b);
        for (int w = 0; w < 8; w++) begin
            checks++;
            if ({pkt_vld, idx, done, pkt} !== {1'b1, 3'(w), 1'b0, wb[w]}) begin
                errors++;
                $display("FAIL b2b_w%0d: got vld=%b idx=%0d done=%b pkt=%h want vld=1 idx=%0d done=0 pkt=%h",
                         w, pkt_vld, idx, done, pkt, w, wb[w]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got done=%b want 1", done);
        end
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clr     = 1'b0;
        ld      = 1'b0;
        pkt_rdy = 1'b0;
        blk     = 512'd0;
        blk_a   = 512'd0;
        blk_b   = 512'd0;
        for (int w = 0; w < 8; w++) begin
            wa[w] = 64'(w + 1);
            wb[w] = 64'hC0DE_0000_0000_0000 | 64'(w * 17 + 3);
            blk_a[511 - 64 * w -: 64] = wa[w];
            blk_b[511 - 64 * w -: 64] = wb[w];
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_ld_ignored();
        test_clr();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sha2_opu_dpath
